// File: rtl/within_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : within_seq_pkg
// Brief    : Shared types, default window bounds and the delay clamp helper
//            for the within-window stimulus generator.
// Revision : 1.0  initial release
// ============================================================================
package within_seq_pkg;

  // Sequencer phases: waiting for a rise, emitting b, counting to c
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B_PH = 2'd1,
    WIN  = 2'd2
  } state_t;

  localparam int DEF_C_MIN = 3;
  localparam int DEF_C_MAX = 5;

  // Saturate a requested delay into [lo, hi]
  function automatic int clamp(input int val, input int lo, input int hi);
    if (val < lo) begin
      return lo;
    end else if (val > hi) begin
      return hi;
    end else begin
      return val;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/within_seq_gen_rise_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_det
// Brief    : Registered copy of the trigger level and a 0->1 rise strobe.
// Revision : 1.0  initial release
// ============================================================================
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic rise
);

  logic trig_q;

  // Track last cycle's trigger level every cycle, so a held trigger never re-fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
    end
  end

  assign rise = trig & ~trig_q;

endmodule
`default_nettype wire

// File: rtl/within_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : within_seq_gen
// Brief    : On a trigger rise emits b, then a, then c single-cycle pulses,
//            with a always inside the b..c window at programmable offsets.
// Revision : 1.0  initial release
// ============================================================================
module within_seq_gen
  import within_seq_pkg::*;
#(
  parameter int C_MIN  = DEF_C_MIN,
  parameter int C_MAX  = DEF_C_MAX,
  parameter int CNT_W  = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [CNT_W-1:0]  c_dly,
  input  logic [CNT_W-1:0]  a_dly,
  output logic              b_o,
  output logic              a_o,
  output logic              c_o,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [DROP_W-1:0] drop_cnt
);

  // The counter must be able to reach Kc; Kc below 2 would collide with b
  if (C_MAX >= (1 << CNT_W)) begin : g_cmax_check
    $error("within_seq_gen: C_MAX does not fit in CNT_W bits");
  end
  if ((C_MIN < 2) || (C_MIN > C_MAX)) begin : g_cmin_check
    $error("within_seq_gen: C_MIN must be in [2, C_MAX]");
  end

  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] ka;
  logic [CNT_W-1:0] kc;
  logic [CNT_W-1:0] kc_new;
  logic [CNT_W-1:0] ka_new;
  logic             clamped;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig),
    .rise  (rise)
  );

  // Clamp the live delay inputs; only used on the accepting edge
  always_comb begin
    kc_new  = CNT_W'(clamp(int'(c_dly), C_MIN, C_MAX));
    ka_new  = CNT_W'(clamp(int'(a_dly), 1, int'(kc_new)));
    clamped = (kc_new != c_dly) || (ka_new != a_dly);
    cnt_nxt = cnt + CNT_W'(1);
  end

  // Sequencer: outputs are registered one edge ahead of the cycle they mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ka      <= '0;
      kc      <= '0;
      b_o     <= 1'b0;
      a_o     <= 1'b0;
      c_o     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          b_o  <= 1'b0;
          a_o  <= 1'b0;
          c_o  <= 1'b0;
          done <= 1'b0;
          if (rise) begin
            state <= B_PH;
            cnt   <= CNT_W'(1);
            kc    <= kc_new;
            ka    <= ka_new;
            b_o   <= 1'b1;
            busy  <= 1'b1;
            if (clamped) begin
              cfg_err <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        B_PH: begin
          // First window cycle carries count 1, so Ka==1 lands right after b
          state <= WIN;
          b_o   <= 1'b0;
          a_o   <= (ka == CNT_W'(1));
        end
        WIN: begin
          if (cnt == kc) begin
            state <= IDLE;
            a_o   <= 1'b0;
            c_o   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt_nxt;
            a_o  <= (cnt_nxt == ka);
            c_o  <= (cnt_nxt == kc);
            done <= (cnt_nxt == kc);
          end
        end
        default: begin
          state <= IDLE;
          b_o   <= 1'b0;
          a_o   <= 1'b0;
          c_o   <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Count rises that arrive while a sequence is in flight, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (rise && (state != IDLE) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_within_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_within_seq_gen
// Brief    : Directed, table-driven bench for within_seq_gen.
// Revision : 1.0  initial release
// ============================================================================
module tb_within_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig;
  logic [2:0] c_dly;
  logic [2:0] a_dly;
  logic       b_o, a_o, c_o, busy, done, cfg_err;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-edge logs: bit j holds the output seen just after edge j of a run
  logic [63:0] b_log, a_log, c_log, d_log, y_log;

  typedef struct {
    logic [2:0] c;
    logic [2:0] a;
    int         ka;
    int         kc;
    int         err;
  } vec_t;

  vec_t vecs[6];

  within_seq_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .c_dly    (c_dly),
    .a_dly    (a_dly),
    .b_o      (b_o),
    .a_o      (a_o),
    .c_o      (c_o),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Protocol invariants that must hold in every scenario
  ap_done_c:  assert property (@(posedge clk) disable iff (!rst_n) done == c_o);
  ap_a_win:   assert property (@(posedge clk) disable iff (!rst_n) a_o |-> (busy && !b_o));
  ap_c_win:   assert property (@(posedge clk) disable iff (!rst_n) c_o |-> (busy && !b_o));
  ap_b_once:  assert property (@(posedge clk) disable iff (!rst_n) b_o |=> !b_o);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int first_from(input logic [63:0] v, input int from);
    for (int i = from; i < 64; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive trig from wave bit j before edge j, log outputs just after edge j
  task automatic run_wave(input logic [63:0] wave, input int n,
                          input logic [2:0] cd, input logic [2:0] ad);
    b_log = '0; a_log = '0; c_log = '0; d_log = '0; y_log = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      trig  = wave[j];
      c_dly = cd;
      a_dly = ad;
      @(posedge clk);
      #1;
      b_log[j] = b_o;
      a_log[j] = a_o;
      c_log[j] = c_o;
      d_log[j] = done;
      y_log[j] = busy;
    end
    @(negedge clk);
    trig = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd4, 3'd2, 2, 4, 0};
    vecs[1] = '{3'd3, 3'd3, 3, 3, 0};
    vecs[2] = '{3'd5, 3'd1, 1, 5, 0};
    vecs[3] = '{3'd7, 3'd6, 5, 5, 1};
    vecs[4] = '{3'd0, 3'd0, 1, 3, 1};
    vecs[5] = '{3'd4, 3'd5, 4, 4, 1};

    rst_n = 1'b0;
    trig  = 1'b0;
    c_dly = 3'd0;
    a_dly = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pulses", int'({b_o, a_o, c_o, busy, done}), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_release", int'({b_o, a_o, c_o, busy, done}), 0);

    // Single-rise table: timing of b/a/c against clamped delays
    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_wave(64'h1, 10, vecs[v].c, vecs[v].a);
      check($sformatf("v%0d_b_at", v), first_from(b_log, 0), 0);
      check($sformatf("v%0d_b_count", v), $countones(b_log), 1);
      check($sformatf("v%0d_a_at", v), first_from(a_log, 0), vecs[v].ka);
      check($sformatf("v%0d_a_count", v), $countones(a_log), 1);
      check($sformatf("v%0d_c_at", v), first_from(c_log, 0), vecs[v].kc);
      check($sformatf("v%0d_c_count", v), $countones(c_log), 1);
      check($sformatf("v%0d_done_at", v), first_from(d_log, 0), vecs[v].kc);
      check($sformatf("v%0d_busy_len", v), $countones(y_log), vecs[v].kc + 1);
      check($sformatf("v%0d_busy_start", v), first_from(y_log, 0), 0);
      check($sformatf("v%0d_cfg_err", v), int'(cfg_err), vecs[v].err);
      check($sformatf("v%0d_drop_cnt", v), int'(drop_cnt), 0);
    end

    // Second rise during WIN is dropped
    do_reset();
    run_wave(64'h9, 14, 3'd4, 3'd2);
    check("busy_drop_b_count", $countones(b_log), 1);
    check("busy_drop_c_count", $countones(c_log), 1);
    check("busy_drop_cnt", int'(drop_cnt), 1);

    // Rise on the edge that leaves WIN is dropped (Kc=3)
    do_reset();
    run_wave(64'h11, 14, 3'd3, 3'd1);
    check("leave_edge_b_count", $countones(b_log), 1);
    check("leave_edge_drop_cnt", int'(drop_cnt), 1);

    // Rise one edge later is accepted and b follows immediately
    do_reset();
    run_wave(64'h21, 14, 3'd3, 3'd1);
    check("b2b_b_count", $countones(b_log), 2);
    check("b2b_second_b_at", first_from(b_log, 1), 5);
    check("b2b_second_c_at", first_from(c_log, 4), 8);
    check("b2b_drop_cnt", int'(drop_cnt), 0);

    // Held-high trigger produces one sequence only
    do_reset();
    run_wave(64'hFFFFF, 30, 3'd4, 3'd2);
    check("held_b_count", $countones(b_log), 1);
    check("held_c_count", $countones(c_log), 1);
    check("held_drop_cnt", int'(drop_cnt), 0);

    // Delay inputs changed mid-sequence have no effect
    do_reset();
    b_log = '0; a_log = '0; c_log = '0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      trig  = (j == 0);
      c_dly = (j == 0) ? 3'd5 : 3'd3;
      a_dly = (j == 0) ? 3'd4 : 3'd1;
      @(posedge clk);
      #1;
      b_log[j] = b_o;
      a_log[j] = a_o;
      c_log[j] = c_o;
    end
    check("latch_a_at", first_from(a_log, 0), 4);
    check("latch_c_at", first_from(c_log, 0), 5);

    // Toggling trigger: accept at 0 and 8, drops at 2,4,6,10,12,14 with Kc=5
    do_reset();
    run_wave(64'h5555, 16, 3'd5, 3'd3);
    check("toggle_b_count", $countones(b_log), 2);
    check("toggle_drop_cnt", int'(drop_cnt), 6);
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      trig = ~trig;
    end
    @(negedge clk);
    trig = 1'b0;
    @(posedge clk);
    #1;
    check("drop_saturates", int'(drop_cnt), 255);

    // Reset in the middle of WIN clears outputs at once, no stray pulses after
    do_reset();
    run_wave(64'h1, 3, 3'd4, 3'd2);
    check("midreset_a_before", int'(a_log[2]), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_async_clear", int'({b_o, a_o, c_o, busy, done}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_wave(64'h0, 10, 3'd4, 3'd2);
    check("post_reset_no_pulses", $countones(b_log | a_log | c_log | y_log), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
